// File: rtl/shifter_pkg.sv
// Shared definitions for the ALU-stage shifter.
//   DEFAULT_WIDTH  default datapath width of shifter_unit / shifter_core
//   SHIFT_TYPE_W   width of the controller's shift_type code
//   shift_type_e   SLL / SRL / SRA / ROR operation encodings
package shifter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned SHIFT_TYPE_W  = 2;

    typedef enum logic [SHIFT_TYPE_W-1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

endpackage

// File: rtl/shifter_core.sv
// Combinational barrel network for the ALU-stage shifter.
// Ports:
//   value       in   WIDTH  operand
//   shift_type  in   2      SLL / SRL / SRA / ROR
//   distance    in   WIDTH  full shift amount (ROR only looks at the low log2(WIDTH) bits)
//   result_c    out  WIDTH  shifted / rotated value
//   carry_c     out  1      last bit shifted out (only with SHIFTER_CARRY_OUT_EN)
// Optional feature macro: SHIFTER_CARRY_OUT_EN.
// WIDTH must be a power of two so the low distance bits form the in-range amount.
module shifter_core
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]        value,
    input  logic [SHIFT_TYPE_W-1:0] shift_type,
    input  logic [WIDTH-1:0]        distance,
`ifdef SHIFTER_CARRY_OUT_EN
    output logic                    carry_c,
`endif
    output logic [WIDTH-1:0]        result_c
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // Mirror a vector so a left shift can reuse the right-shift network.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = x[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

    shift_type_e      op;
    logic             rotate;
    logic             reverse;
    logic             fill;
    logic             over_range;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] oriented;
    logic [WIDTH-1:0] right_out;

    // Operation decode: SLL runs through the right shifter on a mirrored operand.
    assign op         = shift_type_e'(shift_type);
    assign rotate     = (op == SHIFT_ROR);
    assign reverse    = (op == SHIFT_SLL);
    assign fill       = (op == SHIFT_SRA) & value[WIDTH-1];
    assign over_range = |distance[WIDTH-1:SHW];
    assign amt        = distance[SHW-1:0];
    assign oriented   = reverse ? bit_rev(value) : value;

    // Log-stage right barrel: stage k shifts by 2**k, feeding in fill or wrapped bits.
    logic [SHW:0][WIDTH-1:0] stage;
    assign stage[0] = oriented;

    for (genvar k = 0; k < int'(SHW); k++) begin : g_stage
        localparam int unsigned S = 1 << k;
        logic [S-1:0] fill_bits;
        assign fill_bits    = rotate ? stage[k][S-1:0] : {S{fill}};
        assign stage[k+1]   = amt[k] ? {fill_bits, stage[k][WIDTH-1:S]} : stage[k];
    end

    // Any distance >= WIDTH empties the word for the non-rotating shifts.
    assign right_out = (over_range && !rotate) ? {WIDTH{fill}} : stage[SHW];
    assign result_c  = reverse ? bit_rev(right_out) : right_out;

`ifdef SHIFTER_CARRY_OUT_EN
    logic           dist_zero;
    logic           dist_gt;
    logic [SHW-1:0] carry_idx;

    // Bit d-1 of the oriented operand is the last one to leave; for SLL the
    // mirror turns that into value[WIDTH-d]. distance == WIDTH wraps to the top bit.
    assign dist_zero = (distance == '0);
    assign dist_gt   = (distance > WIDTH'(WIDTH));
    assign carry_idx = SHW'(distance - WIDTH'(1));

    // Carry select; ROR reports the bit that lands in the MSB.
    always_comb begin
        carry_c = 1'b0;
        if (dist_zero) begin
            carry_c = 1'b0;
        end else if (rotate) begin
            carry_c = result_c[WIDTH-1];
        end else if (dist_gt) begin
            carry_c = (op == SHIFT_SRA) ? value[WIDTH-1] : 1'b0;
        end else begin
            carry_c = oriented[carry_idx];
        end
    end
`endif

endmodule

// File: rtl/shifter_unit.sv
// Registered shifter for the ALU stage: one-cycle latency, full throughput.
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset (wins over in_valid)
//   in_valid    in   1      operands valid this cycle
//   value       in   WIDTH  operand to shift
//   shift_type  in   2      SLL=00, SRL=01, SRA=10, ROR=11
//   distance    in   WIDTH  shift amount (read_data2)
//   result      out  WIDTH  registered result, holds when in_valid is low
//   carry_out   out  1      last bit shifted out (only with SHIFTER_CARRY_OUT_EN)
//   out_valid   out  1      in_valid delayed by one cycle
// Optional feature macro: SHIFTER_CARRY_OUT_EN.
module shifter_unit
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        value,
    input  logic [SHIFT_TYPE_W-1:0] shift_type,
    input  logic [WIDTH-1:0]        distance,
    output logic [WIDTH-1:0]        result,
`ifdef SHIFTER_CARRY_OUT_EN
    output logic                    carry_out,
`endif
    output logic                    out_valid
);

    logic [WIDTH-1:0] next_result_c;
`ifdef SHIFTER_CARRY_OUT_EN
    logic             next_carry_c;
`endif

    shifter_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .value      (value),
        .shift_type (shift_type),
        .distance   (distance),
`ifdef SHIFTER_CARRY_OUT_EN
        .carry_c    (next_carry_c),
`endif
        .result_c   (next_result_c)
    );

    // Output register and valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
`ifdef SHIFTER_CARRY_OUT_EN
            carry_out <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= next_result_c;
`ifdef SHIFTER_CARRY_OUT_EN
                carry_out <= next_carry_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_shifter_unit.sv
// Directed self-checking bench for shifter_unit.
module tb_shifter_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] value;
    logic [1:0]  shift_type;
    logic [15:0] distance;
    logic [15:0] result;
    logic        out_valid;
`ifdef SHIFTER_CARRY_OUT_EN
    logic        carry_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    shifter_unit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .value      (value),
        .shift_type (shift_type),
        .distance   (distance),
        .result     (result),
`ifdef SHIFTER_CARRY_OUT_EN
        .carry_out  (carry_out),
`endif
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of stimulus at negedge, return just after the capturing edge.
    task automatic drive(input logic r, input logic v, input logic [1:0] t,
                         input logic [15:0] val, input logic [15:0] d);
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        shift_type = t;
        value      = val;
        distance   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        n_cmp++;
        if (result !== 16'h0000) begin
            n_bad++; $display("FAIL reset_result got=%h exp=0000", result);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
`ifdef SHIFTER_CARRY_OUT_EN
        n_cmp++;
        if (carry_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_carry got=%b exp=0", carry_out);
        end
`endif
    endtask

    // Ordinary in-range shifts of each type, plus a few extra directed points.
    task automatic test_ops();
        logic [1:0]  t  [8];
        logic [15:0] v  [8];
        logic [15:0] d  [8];
        logic [15:0] er [8];
        logic        ec [8];
        t  = '{2'b00,   2'b01,   2'b10,   2'b11,   2'b00,   2'b01,   2'b10,   2'b11};
        v  = '{16'h9816,16'h8816,16'hF816,16'h9816,16'h0001,16'h8000,16'h7FF0,16'h0001};
        d  = '{16'd3,   16'd3,   16'd3,   16'd4,   16'd15,  16'd15,  16'd4,   16'd1};
        er = '{16'hC0B0,16'h1102,16'hFF02,16'h6981,16'h8000,16'h0001,16'h07FF,16'h8000};
        ec = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, t[i], v[i], d[i]);
            n_cmp++;
            if (result !== er[i]) begin
                n_bad++; $display("FAIL ops[%0d]_result got=%h exp=%h", i, result, er[i]);
            end
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++; $display("FAIL ops[%0d]_out_valid got=%b exp=1", i, out_valid);
            end
`ifdef SHIFTER_CARRY_OUT_EN
            n_cmp++;
            if (carry_out !== ec[i]) begin
                n_bad++; $display("FAIL ops[%0d]_carry got=%b exp=%b", i, carry_out, ec[i]);
            end
`else
            if (ec[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_distance_zero();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 16'hA5C3, 16'h0000);
            n_cmp++;
            if (result !== 16'hA5C3) begin
                n_bad++; $display("FAIL dist0_type%0d got=%h exp=a5c3", i, result);
            end
`ifdef SHIFTER_CARRY_OUT_EN
            n_cmp++;
            if (carry_out !== 1'b0) begin
                n_bad++; $display("FAIL dist0_type%0d_carry got=%b exp=0", i, carry_out);
            end
`endif
        end
    endtask

    // Distances at and beyond the word width, including high-only distance bits.
    task automatic test_over_range();
        logic [1:0]  t  [7];
        logic [15:0] v  [7];
        logic [15:0] d  [7];
        logic [15:0] er [7];
        logic        ec [7];
        t  = '{2'b10,   2'b00,   2'b01,   2'b10,   2'b00,   2'b01,   2'b10};
        v  = '{16'h8000,16'h8000,16'h8000,16'h8000,16'hFFFF,16'hFFFF,16'h7FFF};
        d  = '{16'h0010,16'h0010,16'h0010,16'h0020,16'h0100,16'h0011,16'h8000};
        er = '{16'hFFFF,16'h0000,16'h0000,16'hFFFF,16'h0000,16'h0000,16'h0000};
        ec = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, t[i], v[i], d[i]);
            n_cmp++;
            if (result !== er[i]) begin
                n_bad++; $display("FAIL over[%0d]_result got=%h exp=%h", i, result, er[i]);
            end
`ifdef SHIFTER_CARRY_OUT_EN
            n_cmp++;
            if (carry_out !== ec[i]) begin
                n_bad++; $display("FAIL over[%0d]_carry got=%b exp=%b", i, carry_out, ec[i]);
            end
`else
            if (ec[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_rotate_wrap();
        drive(1'b0, 1'b1, 2'b11, 16'h9816, 16'h0014);
        n_cmp++;
        if (result !== 16'h6981) begin
            n_bad++; $display("FAIL ror_0x14 got=%h exp=6981", result);
        end
        drive(1'b0, 1'b1, 2'b11, 16'h1234, 16'hFFF8);
        n_cmp++;
        if (result !== 16'h3412) begin
            n_bad++; $display("FAIL ror_0xfff8 got=%h exp=3412", result);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t  [4];
        logic [15:0] v  [4];
        logic [15:0] d  [4];
        logic [15:0] er [4];
        t  = '{2'b00,   2'b01,   2'b10,   2'b11};
        v  = '{16'h00FF,16'hFF00,16'h8001,16'h000F};
        d  = '{16'd8,   16'd4,   16'd1,   16'd4};
        er = '{16'hFF00,16'h0FF0,16'hC000,16'hF000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, t[i], v[i], d[i]);
            n_cmp++;
            if (out_valid !== 1'b1 || result !== er[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d] got valid=%b result=%h exp valid=1 result=%h",
                         i, out_valid, result, er[i]);
            end
        end
        drive(1'b0, 1'b0, 2'b00, 16'h1111, 16'd1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end_out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 2'b01, 16'hBEEF, 16'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b00, 16'h1234, 16'd1);
            n_cmp++;
            if (result !== 16'h0BEE || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] got result=%h valid=%b exp result=0bee valid=0",
                         i, result, out_valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 2'b00, 16'h0F0F, 16'd4);
        n_cmp++;
        if (result !== 16'hF0F0) begin
            n_bad++; $display("FAIL rstpri_preload got=%h exp=f0f0", result);
        end
        drive(1'b1, 1'b1, 2'b00, 16'h0F0F, 16'd4);
        n_cmp++;
        if (result !== 16'h0000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstpri got result=%h valid=%b exp result=0000 valid=0",
                     result, out_valid);
        end
`ifdef SHIFTER_CARRY_OUT_EN
        n_cmp++;
        if (carry_out !== 1'b0) begin
            n_bad++; $display("FAIL rstpri_carry got=%b exp=0", carry_out);
        end
`endif
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'd0);
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstpri_after got result=%h valid=%b exp result=0000 valid=0",
                     result, out_valid);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        value      = '0;
        shift_type = '0;
        distance   = '0;
        test_reset();
        test_ops();
        test_distance_zero();
        test_over_range();
        test_rotate_wrap();
        test_back_to_back();
        test_hold();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
